operand_stack: RTL and testbench
================================

Name: operand_stack

Overview:
LIFO operand stack that serves the CPU control unit's stack interface: push, pop, data_to_push, stack_clk strobe and data_from_stack.
- Receives command strobes from the control FSM, executes push, pop or replace, and presents top-of-stack (TOS) and next-on-stack (NOS).
- Tracks depth and full/empty, and reports overflow/underflow.
- Sits between the control unit and the ALU temp registers; single clock domain (clk).

Parameters:
WIDTH, 8, data word width
ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W entries (16)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
stack_clk  input  1  command strobe from control unit; rising edge (sampled on clk) fires a command
push  input  1  push request, sampled on the firing cycle
pop  input  1  pop request, sampled on the firing cycle
data_to_push  input  WIDTH  push operand, sampled on the firing cycle
err_clear  input  1  clears overflow/underflow flags (and trap state if compiled in)
data_from_stack  output  WIDTH  registered TOS; 0 when empty
next_on_stack  output  WIDTH  registered NOS; 0 when depth<2
depth  output  ADDR_W+1  current entry count, 0..DEPTH
empty  output  1  depth==0
full  output  1  depth==DEPTH
ack  output  1  one-cycle pulse when a command completes
busy  output  1  high while FSM not in S_IDLE
overflow  output  1  sticky; push attempted while full
underflow  output  1  sticky; pop attempted while empty

Behaviour:
- Reset values: depth=0, empty=1, full=0, data_from_stack=0, next_on_stack=0, ack=0, busy=0, overflow=0, underflow=0, FSM=S_IDLE, strobe_q=0. Memory contents are don't-care and never visible when empty.
- Edge detect: strobe_q <= stack_clk every cycle. fire = stack_clk & ~strobe_q & (state==S_IDLE).
  - Edges arriving while busy are dropped (not queued).
  - A stack_clk held high does not re-fire.
- FSM:
  - S_IDLE: on fire, latch push/pop/data_to_push into cmd regs -> S_EXEC.
  - S_EXEC: perform the operation, update the pointer and flags -> S_ACK.
  - S_ACK: refresh data_from_stack/next_on_stack from the new pointer, ack=1 -> S_IDLE.
  - S_ERR exists only with the optional feature.
- Latency: fire at cycle N; ack high and new TOS/NOS/depth valid at cycle N+2. busy is high in cycles N+1 and N+2.
- Operation decode (depth before = d):
  - push only, d<DEPTH: mem[d]<=data; depth=d+1.
  - push only, d==DEPTH: no write, depth unchanged, overflow<=1.
  - pop only, d>0: depth=d-1. The popped value is the TOS presented before the command, so the consumer samples data_from_stack before firing.
  - pop only, d==0: no change, underflow<=1, data_from_stack stays 0.
  - push+pop, d>0: replace TOS, mem[d-1]<=data, depth unchanged. Never overflows, even when full.
  - push+pop, d==0: no write, underflow<=1.
  - neither asserted: no-op; ack still pulses.
- Pointer arithmetic: depth is ADDR_W+1 bits and never wraps. Write index is depth[ADDR_W-1:0] for push and depth-1 for replace.
- Flags:
  - empty and full are combinational from depth.
  - overflow/underflow are sticky until err_clear or reset.
  - err_clear has priority over a same-cycle flag set, so the flag ends cleared.
- Reset mid-operation: reset wins in any state. FSM returns to S_IDLE, all outputs take their reset values, any in-flight command is discarded, and no ack is produced.

Optional Feature:
Macro: STACK_ERR_TRAP_EN
- With macro: an overflow or underflow in S_EXEC goes to S_ERR instead of S_ACK.
  - S_ERR: busy=1, no ack, all strobes ignored, contents frozen.
  - Exits to S_IDLE only on err_clear (flags cleared) or reset.
- Without macro: no S_ERR state. Errored commands complete through S_ACK with ack and keep the sticky flags; later commands proceed normally.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 (one stack_clk pulse each) -> after each ack: depth 1/2/3; final data_from_stack=0x33, next_on_stack=0x22; ack exactly 2 cycles after each rising edge.
- From depth 3, pop twice -> data_from_stack 0x22 then 0x11, depth 1; third and fourth pops -> depth 0, empty=1, data_from_stack=0, underflow=1 on the fourth.
- Fill to 16 entries (values 0x00..0x0F) -> full=1; push 0xAA -> depth stays 16, TOS 0x0F, overflow=1; push+pop with 0xBB -> TOS 0xBB, depth 16.
- Hold stack_clk high for 5 cycles with push=1, data 0x44 -> exactly one push (depth +1). Pulse stack_clk again while busy -> ignored, depth unchanged.
- Assert reset in S_EXEC of a push -> next cycle depth=0, ack=0, busy=0, flags 0; no ack ever appears for that command.
- With STACK_ERR_TRAP_EN: pop on empty -> busy stays 1, further pushes ignored; err_clear -> S_IDLE, underflow=0, then push 0x55 succeeds with TOS=0x55.

Source files
------------

// File: rtl/operand_stack.sv
// operand_stack: LIFO operand stack driven by a strobed command interface.
// A rising edge of stack_clk (sampled on clk) fires one push, pop, replace
// or no-op command; TOS/NOS, depth and ack are valid two cycles later.
// TOS and NOS are held in registers; the array stores every entry and is read
// through a single registered port that prefetches the entry under NOS.
// Optional feature macro: STACK_ERR_TRAP_EN (an errored command parks the
// FSM in S_ERR until err_clear or reset).
module operand_stack #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stack_clk,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  data_to_push,
    input  logic              err_clear,
    output logic [WIDTH-1:0]  data_from_stack,
    output logic [WIDTH-1:0]  next_on_stack,
    output logic [ADDR_W:0]   depth,
    output logic              empty,
    output logic              full,
    output logic              ack,
    output logic              busy,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_D      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   TWO_D      = {{(ADDR_W-1){1'b0}}, 2'b10};
    localparam logic [ADDR_W-1:0] ONE_A      = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] THREE_A    = {{(ADDR_W-2){1'b0}}, 2'b11};

`ifdef STACK_ERR_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ACK, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ACK} state_t;
`endif

    state_t             state_reg;
    state_t             state_next;
    logic               strobe_q;
    logic               fire;
    logic               cmd_push_reg;
    logic               cmd_pop_reg;
    logic [WIDTH-1:0]   cmd_data_reg;
    logic [ADDR_W:0]    depth_reg;
    logic [WIDTH-1:0]   tos_reg;
    logic [WIDTH-1:0]   nos_reg;
    logic [WIDTH-1:0]   rd_reg;
    logic               overflow_reg;
    logic               underflow_reg;
    logic [WIDTH-1:0]   mem [0:(1<<ADDR_W)-1];

    logic               has_entry;
    logic               is_full;
    logic               do_push;
    logic               do_pop;
    logic               do_replace;
    logic               set_overflow;
    logic               set_underflow;
    logic [ADDR_W-1:0]  depth_low;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;

    assign depth_low = depth_reg[ADDR_W-1:0];
    assign has_entry = (depth_reg != '0);
    assign is_full   = (depth_reg == FULL_COUNT);
    assign fire      = stack_clk & ~strobe_q & (state_reg == S_IDLE);
    // Replace rewrites the current top; push writes the first free slot.
    assign wr_addr   = do_replace ? (depth_low - ONE_A) : depth_low;
    // Entry that becomes NOS after a pop (valid when depth >= 3).
    assign rd_addr   = depth_low - THREE_A;

    // Decode the latched command against the depth seen in S_EXEC.
    always_comb begin
        do_push       = 1'b0;
        do_pop        = 1'b0;
        do_replace    = 1'b0;
        set_overflow  = 1'b0;
        set_underflow = 1'b0;
        if (state_reg == S_EXEC) begin
            do_push       = cmd_push_reg & ~cmd_pop_reg & ~is_full;
            do_pop        = cmd_pop_reg & ~cmd_push_reg & has_entry;
            do_replace    = cmd_push_reg & cmd_pop_reg & has_entry;
            set_overflow  = cmd_push_reg & ~cmd_pop_reg & is_full;
            set_underflow = cmd_pop_reg & ~has_entry;
        end
    end

    // Next-state logic for the command FSM.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (fire) state_next = S_EXEC;
`ifdef STACK_ERR_TRAP_EN
            S_EXEC: state_next = (set_overflow | set_underflow) ? S_ERR : S_ACK;
            S_ERR:  if (err_clear) state_next = S_IDLE;
`else
            S_EXEC: state_next = S_ACK;
`endif
            S_ACK:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register, command latch, pointer, TOS/NOS and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            strobe_q      <= 1'b0;
            cmd_push_reg  <= 1'b0;
            cmd_pop_reg   <= 1'b0;
            cmd_data_reg  <= '0;
            depth_reg     <= '0;
            tos_reg       <= '0;
            nos_reg       <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            strobe_q  <= stack_clk;
            if (fire) begin
                cmd_push_reg <= push;
                cmd_pop_reg  <= pop;
                cmd_data_reg <= data_to_push;
            end
            if (do_push) begin
                depth_reg <= depth_reg + ONE_D;
                tos_reg   <= cmd_data_reg;
                nos_reg   <= tos_reg;
            end
            if (do_pop) begin
                depth_reg <= depth_reg - ONE_D;
                tos_reg   <= nos_reg;
                nos_reg   <= (depth_reg > TWO_D) ? rd_reg : '0;
            end
            if (do_replace) begin
                tos_reg <= cmd_data_reg;
            end
            if (set_overflow)  overflow_reg  <= 1'b1;
            if (set_underflow) underflow_reg <= 1'b1;
            // A clear in the same cycle as a new error leaves the flag clear.
            if (err_clear) begin
                overflow_reg  <= 1'b0;
                underflow_reg <= 1'b0;
            end
        end
    end

    // Storage array: single write port, registered read of the NOS-refill entry.
    always_ff @(posedge clk) begin
        if (do_push | do_replace) begin
            mem[wr_addr] <= cmd_data_reg;
        end
        rd_reg <= mem[rd_addr];
    end

    assign data_from_stack = tos_reg;
    assign next_on_stack   = nos_reg;
    assign depth           = depth_reg;
    assign empty           = (depth_reg == '0);
    assign full            = is_full;
    assign ack             = (state_reg == S_ACK);
    assign busy            = (state_reg != S_IDLE);
    assign overflow        = overflow_reg;
    assign underflow       = underflow_reg;

endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed scoreboard bench for operand_stack.
// Stimulus queues the hand-computed state expected at each ack; a monitor
// pops and compares on every ack, including the ack cycle number.
module tb_operand_stack;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stack_clk = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic [WIDTH-1:0]  data_to_push = '0;
    logic              err_clear = 1'b0;
    logic [WIDTH-1:0]  data_from_stack;
    logic [WIDTH-1:0]  next_on_stack;
    logic [ADDR_W:0]   depth;
    logic              empty, full, ack, busy, overflow, underflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack_seen = 0;
    logic exp_ovf = 1'b0;
    logic exp_udf = 1'b0;

    typedef struct {
        logic [7:0] tos;
        logic [7:0] nos;
        logic [4:0] dep;
        logic       ovf;
        logic       udf;
        int         ack_cyc;
        string      name;
    } exp_t;
    exp_t sb[$];

    operand_stack #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .stack_clk(stack_clk), .push(push), .pop(pop),
        .data_to_push(data_to_push), .err_clear(err_clear),
        .data_from_stack(data_from_stack), .next_on_stack(next_on_stack),
        .depth(depth), .empty(empty), .full(full), .ack(ack), .busy(busy),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ack === 1'b1) begin
            ack_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_tos"}, data_from_stack, e.tos);
                chk({e.name, "_nos"}, next_on_stack, e.nos);
                chk({e.name, "_depth"}, depth, e.dep);
                chk({e.name, "_empty_full"}, {empty, full},
                    {(e.dep == 5'd0), (e.dep == 5'd16)});
                chk({e.name, "_flags"}, {overflow, underflow}, {e.ovf, e.udf});
                chk({e.name, "_latency"}, cyc, e.ack_cyc);
                $display("txn %s: tos=%02h nos=%02h depth=%0d ovf=%0b udf=%0b cyc=%0d",
                         e.name, data_from_stack, next_on_stack, depth, overflow, underflow, cyc);
            end
        end
    end

    task automatic queue_exp(input string name, input logic [7:0] t, input logic [7:0] n,
                             input logic [4:0] d);
        exp_t e;
        e.tos = t; e.nos = n; e.dep = d;
        e.ovf = exp_ovf; e.udf = exp_udf;
        e.ack_cyc = cyc + 2;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string name, input int start);
        for (int i = 0; i < 8 && ack_seen == start; i++) begin
            @(negedge clk); #1;
        end
        if (ack_seen == start) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ack expected ack within 8 cycles", name);
            if (sb.size() > 0) void'(sb.pop_back());
        end
    endtask

    task automatic clear_errors(input string name);
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        chk({name, "_clr_flags"}, {overflow, underflow}, 2'b00);
        chk({name, "_clr_busy"}, busy, 1'b0);
    endtask

    // err: 0 none, 1 overflow expected, 2 underflow expected.
    task automatic cmd(input string name, input logic p, input logic q, input logic [7:0] d,
                       input logic [7:0] t, input logic [7:0] n, input logic [4:0] dep,
                       input int err);
        int start;
        @(posedge clk); #1;
        if (err == 1) exp_ovf = 1'b1;
        if (err == 2) exp_udf = 1'b1;
`ifdef STACK_ERR_TRAP_EN
        if (err != 0) begin
            push = p; pop = q; data_to_push = d; stack_clk = 1'b1;
            @(posedge clk); #1;
            stack_clk = 1'b0; push = 1'b0; pop = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            chk({name, "_trap_busy"}, busy, 1'b1);
            chk({name, "_trap_flags"}, {overflow, underflow}, {exp_ovf, exp_udf});
            push = 1'b1; data_to_push = 8'hEE; stack_clk = 1'b1;
            @(posedge clk); #1;
            stack_clk = 1'b0; push = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk({name, "_trap_depth"}, depth, dep);
            chk({name, "_trap_tos"}, data_from_stack, t);
            clear_errors(name);
            return;
        end
`endif
        start = ack_seen;
        queue_exp(name, t, n, dep);
        push = p; pop = q; data_to_push = d; stack_clk = 1'b1;
        @(posedge clk); #1;
        stack_clk = 1'b0; push = 1'b0; pop = 1'b0;
        wait_ack(name, start);
    endtask

    initial begin
        int start;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_depth", depth, 5'd0);
        chk("rst_empty_full", {empty, full}, 2'b10);
        chk("rst_tos_nos", {data_from_stack, next_on_stack}, 16'h0000);
        chk("rst_ack_busy", {ack, busy}, 2'b00);
        chk("rst_flags", {overflow, underflow}, 2'b00);

        // Basic pushes and pops down to underflow
        cmd("push11", 1, 0, 8'h11, 8'h11, 8'h00, 5'd1, 0);
        cmd("push22", 1, 0, 8'h22, 8'h22, 8'h11, 5'd2, 0);
        cmd("push33", 1, 0, 8'h33, 8'h33, 8'h22, 5'd3, 0);
        cmd("pop1",   0, 1, 8'h00, 8'h22, 8'h11, 5'd2, 0);
        cmd("pop2",   0, 1, 8'h00, 8'h11, 8'h00, 5'd1, 0);
        cmd("pop3",   0, 1, 8'h00, 8'h00, 8'h00, 5'd0, 0);
        cmd("pop4",   0, 1, 8'h00, 8'h00, 8'h00, 5'd0, 2);
        clear_errors("clr1");

        // Fill to capacity, then overflow and replace at full
        for (int i = 0; i < 16; i++) begin
            cmd("fill", 1, 0, 8'(i), 8'(i), (i == 0) ? 8'h00 : 8'(i - 1), 5'(i + 1), 0);
        end
        chk("fill_full", full, 1'b1);
        cmd("push_full", 1, 0, 8'hAA, 8'h0F, 8'h0E, 5'd16, 1);
        cmd("replace_full", 1, 1, 8'hBB, 8'hBB, 8'h0E, 5'd16, 0);
        cmd("pop_refill", 0, 1, 8'h00, 8'h0E, 8'h0D, 5'd15, 0);

        // stack_clk held high for 5 cycles fires exactly once
        @(posedge clk); #1;
        start = ack_seen;
        queue_exp("hold44", 8'h44, 8'h0E, 5'd16);
        push = 1'b1; data_to_push = 8'h44; stack_clk = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        stack_clk = 1'b0; push = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("hold_ack_count", ack_seen - start, 1);
        chk("hold_depth", depth, 5'd16);

        // Edge while busy is dropped
        @(posedge clk); #1;
        start = ack_seen;
        queue_exp("busy_pop", 8'h0E, 8'h0D, 5'd15);
        pop = 1'b1; stack_clk = 1'b1;
        @(posedge clk); #1;
        stack_clk = 1'b0;
        @(posedge clk); #1;
        stack_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stack_clk = 1'b0; pop = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_ack_count", ack_seen - start, 1);
        chk("busy_depth", depth, 5'd15);

        // Reset during S_EXEC of a push
        @(posedge clk); #1;
        start = ack_seen;
        push = 1'b1; data_to_push = 8'h77; stack_clk = 1'b1;
        @(posedge clk); #1;
        stack_clk = 1'b0; push = 1'b0;
        chk("exec_busy", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        chk("midrst_depth", depth, 5'd0);
        chk("midrst_ack_busy", {ack, busy}, 2'b00);
        chk("midrst_flags", {overflow, underflow}, 2'b00);
        chk("midrst_tos", data_from_stack, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_ack", ack_seen - start, 0);
        chk("midrst_depth_after", depth, 5'd0);

        // Replace on empty, no-op, recovery
        cmd("replace_empty", 1, 1, 8'h99, 8'h00, 8'h00, 5'd0, 2);
        cmd("noop", 0, 0, 8'h00, 8'h00, 8'h00, 5'd0, 0);
        clear_errors("clr2");
        cmd("push55", 1, 0, 8'h55, 8'h55, 8'h00, 5'd1, 0);
        cmd("push66", 1, 0, 8'h66, 8'h66, 8'h55, 5'd2, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
